// File: rtl/spectro_frame_deser.sv
// Receive-side deserializer for the spectrogram PISO readout: rebuilds slot-tagged words
// and buffers them in a first-word-fall-through FIFO behind a valid/ready handshake.
module spectro_frame_deser #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WORD_W     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              sl_in,
    input  logic              ovf_in,
    output logic [WORD_W-1:0] word_data,
    output logic [3:0]        word_slot,
    output logic              word_last,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              frame_done,
    output logic              fifo_ovf,
    output logic              frame_err
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned BW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {StIdle, StArmed, StShift} state_e;

    state_e            state_q, state_d;
    logic              ovf_q;
    logic              ovf_rise;
    logic [3:0]        slot_q, slot_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [WORD_W-1:0] shifted;
    logic              push;
    logic              err_set;

    logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
    logic [3:0]        mem_slot [FIFO_DEPTH];
    logic [AW-1:0]     rd_q, wr_q;
    logic [AW:0]       cnt_q;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              frame_done_q, fifo_ovf_q, frame_err_q;

    assign ovf_rise = ovf_in & ~ovf_q;
    assign shifted  = {sreg_q[WORD_W-2:0], serial_in};

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        push    = 1'b0;
        err_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ovf_rise) begin
                    state_d = StArmed;
                    slot_d  = '0;
                end
            end
            StArmed: begin
                if (ovf_rise && slot_q != 4'd0) begin
                    err_set = 1'b1;
                    slot_d  = '0;
                end else if (sl_in) begin
                    state_d = StShift;
                    bit_d   = '0;
                end
            end
            StShift: begin
                if (ovf_rise) begin
                    err_set = 1'b1;
                    slot_d  = '0;
                    bit_d   = '0;
                    state_d = StArmed;
                end else if (sl_in) begin
                    // Early reload: drop the partial word, same slot starts over.
                    err_set = 1'b1;
                    bit_d   = '0;
                end else begin
                    sreg_d = shifted;
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == BW'(WORD_W - 1)) begin
                        push    = 1'b1;
                        slot_d  = slot_q + 4'd1;
                        state_d = (slot_q == 4'd15) ? StIdle : StArmed;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ovf_q   <= 1'b0;
            slot_q  <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_in;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
        end
    end

    assign word_valid = (cnt_q != '0);
    assign full       = (cnt_q == (AW + 1)'(FIFO_DEPTH));
    assign pop        = word_valid & word_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign push_ok    = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_q] <= shifted;
            mem_slot[wr_q] <= slot_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            fifo_ovf_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            if (push_ok && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!push_ok && pop) cnt_q <= cnt_q - 1'b1;
            frame_done_q <= push_ok && (slot_q == 4'd15);
            fifo_ovf_q   <= fifo_ovf_q | (push & ~push_ok);
            frame_err_q  <= frame_err_q | err_set;
        end
    end

    assign word_data  = word_valid ? mem_data[rd_q] : '0;
    assign word_slot  = word_valid ? mem_slot[rd_q] : '0;
    assign word_last  = word_valid && (mem_slot[rd_q] == 4'd15);
    assign frame_done = frame_done_q;
    assign fifo_ovf   = fifo_ovf_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spectro_frame_deser.sv
// Self-checking bench for spectro_frame_deser: scenario tasks drive the serial protocol
// while a queue-based FIFO model predicts every visible word and flag.
module tb_spectro_frame_deser;

    localparam int DEPTH = 4;
    localparam int W     = 12;

    logic          clk = 1'b0;
    logic          reset, serial_in, sl_in, ovf_in, word_ready;
    logic [W-1:0]  word_data;
    logic [3:0]    word_slot;
    logic          word_last, word_valid, frame_done, fifo_ovf, frame_err;

    int            checks = 0;
    int            errors = 0;
    logic [15:0]   q[$];
    bit            exp_ovf, exp_err, exp_fd, rand_ready;

    spectro_frame_deser #(.FIFO_DEPTH(DEPTH), .WORD_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .sl_in      (sl_in),
        .ovf_in     (ovf_in),
        .word_data  (word_data),
        .word_slot  (word_slot),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_done (frame_done),
        .fifo_ovf   (fifo_ovf),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock cycle: compare DUT against the model, then advance the model across the edge.
    task automatic tick(input bit push, input logic [15:0] entry, input bit err_evt);
        bit pop;
        @(negedge clk);
        checks++;
        if (word_valid !== (q.size() > 0)) begin
            errors++;
            $display("FAIL valid: got %b want %b", word_valid, q.size() > 0);
        end
        if (q.size() > 0) begin
            checks++;
            if ({word_slot, word_data} !== q[0]) begin
                errors++;
                $display("FAIL head: got slot %0d data %h want slot %0d data %h",
                         word_slot, word_data, q[0][15:12], q[0][11:0]);
            end
            checks++;
            if (word_last !== (q[0][15:12] == 4'd15)) begin
                errors++;
                $display("FAIL last: got %b want %b", word_last, q[0][15:12] == 4'd15);
            end
        end
        checks++;
        if (frame_done !== exp_fd) begin
            errors++;
            $display("FAIL frame_done: got %b want %b", frame_done, exp_fd);
        end
        checks++;
        if (fifo_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL fifo_ovf: got %b want %b", fifo_ovf, exp_ovf);
        end
        checks++;
        if (frame_err !== exp_err) begin
            errors++;
            $display("FAIL frame_err: got %b want %b", frame_err, exp_err);
        end
        pop = (q.size() > 0) && (word_ready === 1'b1);
        @(posedge clk);
        exp_fd = 1'b0;
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) begin
                q.push_back(entry);
                exp_fd = (entry[15:12] == 4'd15);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        if (err_evt) exp_err = 1'b1;
        #1;
        if (rand_ready) word_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_word(input logic [3:0] slot, input logic [11:0] data,
                             input bit err_on_load, input bit expect_push);
        sl_in = 1'b1;
        tick(1'b0, 16'h0, err_on_load);
        sl_in = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            serial_in = data[i];
            tick(expect_push && (i == 0), {slot, data}, 1'b0);
        end
    endtask

    task automatic start_frame();
        ovf_in = 1'b0;
        tick(1'b0, 16'h0, 1'b0);
        ovf_in = 1'b1;
        tick(1'b0, 16'h0, 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b1; sl_in = 1'b0; ovf_in = 1'b0; serial_in = 1'b0; word_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        exp_ovf = 1'b0; exp_err = 1'b0; exp_fd = 1'b0; rand_ready = 1'b0;
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        word_ready = 1'b1;
        for (int n = 0; n < DEPTH + 3; n++) tick(1'b0, 16'h0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({word_data, word_slot, word_last, word_valid, frame_done, fifo_ovf, frame_err}
            !== '0) begin
            errors++;
            $display("FAIL %s: outputs data %h slot %0d last %b valid %b fd %b ovf %b err %b, want all 0",
                     tag, word_data, word_slot, word_last, word_valid, frame_done, fifo_ovf,
                     frame_err);
        end
    endtask

    function automatic logic [11:0] plan_word(input int s);
        return (s == 0) ? 12'h3C5 : 12'(s * 12'h101);
    endfunction

    task automatic send_frame_rand(input int first, input int last);
        for (int s = first; s <= last; s++) send_word(4'(s), 12'($urandom), 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        apply_reset();
        check_all_zero("reset");
        tick(1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_frame();
        apply_reset();
        word_ready = 1'b1;
        start_frame();
        for (int s = 0; s < 16; s++) send_word(4'(s), plan_word(s), 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_fifo_ovf();
        apply_reset();
        word_ready = 1'b0;
        start_frame();
        for (int s = 0; s < 16; s++) send_word(4'(s), plan_word(s), 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_reload_err();
        apply_reset();
        word_ready = 1'b1;
        start_frame();
        send_frame_rand(0, 1);
        sl_in = 1'b1;
        tick(1'b0, 16'h0, 1'b0);
        sl_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            serial_in = 1'($urandom_range(0, 1));
            tick(1'b0, 16'h0, 1'b0);
        end
        send_word(4'd2, 12'($urandom), 1'b1, 1'b1);
        send_frame_rand(3, 15);
        drain();
    endtask

    task automatic test_ovf_restart();
        apply_reset();
        word_ready = 1'b1;
        start_frame();
        send_frame_rand(0, 7);
        ovf_in = 1'b0;
        tick(1'b0, 16'h0, 1'b0);
        ovf_in = 1'b1;
        tick(1'b0, 16'h0, 1'b1);
        send_frame_rand(0, 15);
        drain();
    endtask

    task automatic test_full_push_pop();
        logic [11:0] d;
        apply_reset();
        word_ready = 1'b0;
        start_frame();
        send_frame_rand(0, 3);
        d = 12'($urandom);
        sl_in = 1'b1;
        tick(1'b0, 16'h0, 1'b0);
        sl_in = 1'b0;
        for (int i = W - 1; i >= 1; i--) begin
            serial_in = d[i];
            tick(1'b0, 16'h0, 1'b0);
        end
        word_ready = 1'b1;
        serial_in  = d[0];
        tick(1'b1, {4'd4, d}, 1'b0);
        word_ready = 1'b0;
        tick(1'b0, 16'h0, 1'b0);
        drain();
    endtask

    task automatic test_random_ready();
        apply_reset();
        rand_ready = 1'b1;
        start_frame();
        send_frame_rand(0, 15);
        start_frame();
        send_frame_rand(0, 15);
        drain();
    endtask

    task automatic test_mid_reset();
        logic [11:0] d;
        apply_reset();
        word_ready = 1'b1;
        start_frame();
        send_frame_rand(0, 8);
        d = 12'($urandom);
        sl_in = 1'b1;
        tick(1'b0, 16'h0, 1'b0);
        sl_in = 1'b0;
        for (int i = W - 1; i >= 7; i--) begin
            serial_in = d[i];
            tick(1'b0, 16'h0, 1'b0);
        end
        serial_in = d[6];
        apply_reset();
        check_all_zero("mid_reset");
        // Idle loads without an overflow edge must not start a word.
        word_ready = 1'b1;
        send_word(4'd0, 12'($urandom), 1'b0, 1'b0);
        start_frame();
        send_frame_rand(0, 15);
        drain();
    endtask

    initial begin
        reset = 1'b1; serial_in = 1'b0; sl_in = 1'b0; ovf_in = 1'b0; word_ready = 1'b0;
        test_reset();
        test_frame();
        test_fifo_ovf();
        test_reload_err();
        test_ovf_restart();
        test_full_push_pop();
        test_random_ready();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spectro_frame_deser.md
# spectro_frame_deser

Receive-side deserializer for the spectrogram extractor's serial readout. It samples the PISO serial stream and the shift/load strobe on the system clock, and rebuilds each 12-bit word. Each word is tagged with its slot index: slot 0 is the RTC min/sec word, slots 1..15 are the channel counters. Tagged words are buffered in a small FIFO behind a valid/ready handshake so a downstream host interface (UART/SPI packer) can drain a full 16-word frame at its own pace.

## Interface
Parameters:
- FIFO_DEPTH, 4, number of buffered tagged words; power of two, 2..16.
- WORD_W, 12, bits per serial word; must match the PISO width.

Ports:
- clk  in  1  system clock, same clock that drives the FSM and PISO register.
- reset  in  1  synchronous, active-high; clears all state.
- serial_in  in  1  PISO serial output, MSB first.
- sl_in  in  1  PISO shift/load strobe; 1 = load cycle, 0 = shift.
- ovf_in  in  1  global overflow flag; its rising edge marks the start of a readout frame.
- word_data  out  WORD_W  reassembled word at FIFO head.
- word_slot  out  4  slot index of word_data (0 = RTC, n = channel n).
- word_last  out  1  high when the head word is slot 15.
- word_valid  out  1  FIFO head holds a word.
- word_ready  in  1  consumer accepts the head word when word_valid & word_ready.
- frame_done  out  1  one-cycle pulse when slot 15 is pushed into the FIFO.
- fifo_ovf  out  1  sticky: a completed word was dropped because the FIFO was full.
- frame_err  out  1  sticky: protocol violation detected; cleared only by reset.

## Operation
- Edge detect: ovf_in is registered once; ovf_rise = ovf_in & ~ovf_q.
- Receive FSM states:
  - IDLE: waits for ovf_rise → ARMED, slot counter set to 0.
  - ARMED: waits for sl_in=1 → SHIFT, bit counter set to 0.
  - SHIFT: shifts serial_in into the LSB of the shift register, one bit per cycle. After WORD_W bits it pushes {slot, word} and returns to ARMED, incrementing the slot counter. After slot 15 is pushed it goes to IDLE.
- Push when FIFO is full: the word is dropped, fifo_ovf is set, and the slot still advances.
- Push and pop in the same cycle while full: the push is accepted.
- sl_in=1 while in SHIFT with bit count ≠ WORD_W: set frame_err, discard the partial word, restart SHIFT with bit counter 0 and the same slot.
- ovf_rise while in ARMED with slot ≠ 0, or while in SHIFT: set frame_err, discard the partial word, slot := 0, go to ARMED.
- sl_in=1 while in IDLE: ignored, no error. This covers the FSM's idle loads.
- FIFO is first-word-fall-through. word_data, word_slot and word_last come straight from the head entry. Head entry contents are don't-care when word_valid=0.
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; slot and bit counters 0; ovf_q 0.

## Timing
- Cycle L: sl_in sampled 1. Cycles L+1..L+WORD_W: serial_in carries bits WORD_W-1..0, sampled at each rising edge.
- The word is pushed at the edge ending cycle L+WORD_W.
- word_valid rises in cycle L+WORD_W+1 if the FIFO was empty. frame_done pulses in that same cycle for slot 15.
- Latency from last bit sampled to word visible: 1 cycle.
- The next load may occur at cycle L+WORD_W+1 at the earliest; back-to-back words need no gap.
- Pop takes effect at the clock edge where word_valid & word_ready; the next entry appears the following cycle.
- Reset asserted mid-frame: on the next edge all state clears, including the sticky flags; partial words are lost.

## Test plan
- After reset, ovf_in 0→1, then 16 loads each followed by 12 bits. Slot 0 = 0x3C5, slot n = n*0x101 & 0xFFF. word_ready held 1 → 16 words in order, slots 0..15 carrying those values; word_last and frame_done only on slot 15; both sticky flags 0.
- Same frame with word_ready=0 and FIFO_DEPTH=4 → slots 0..3 buffered; fifo_ovf=1 after slot 4 completes; draining then yields exactly slots 0..3.
- sl_in pulsed again after 5 bits of slot 2 → frame_err=1; slot 2 is received from the new load; no extra word is pushed.
- ovf_in falls and rises again after slot 7 → frame_err=1; the next completed word is tagged slot 0.
- Push and pop in the same cycle while full → word count unchanged, no fifo_ovf, order preserved.
- reset asserted during bit 6 of slot 9 → next cycle all outputs 0 and FSM idle; a following clean frame is received correctly.
